// File: rtl/bidir_pad_pkg.sv
// Shared types and pad-level constants for the bidirectional pad transmit/receive paths.
package bidir_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        START,
        DATA,
        PARITY,
        STOP,
        TAIL
    } state_t;

    localparam logic PAD_HIZ   = 1'b1;
    localparam logic PAD_DRIVE = 1'b0;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bidir_pad_tx_bit_period_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1, flags the terminal and the
// second-to-last count, and can be forced back to zero on any state entry.
module bit_period_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tc,
    output logic o_pre_tc
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc     = (r_cnt == LAST);
    assign o_pre_tc = (r_cnt == PRE);

endmodule

// File: rtl/bidir_pad_tx.sv
// Transmit driver for one bidirectional pad: serialises frames on pad_o and owns pad_t.
// Build option BIDIR_PAD_TX_PARITY_EN adds a parity slot and the PARITY_ODD parameter.
module bidir_pad_tx
    import bidir_pad_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int GUARD_BITS   = 1,
    parameter int DATA_BITS    = 8
`ifdef BIDIR_PAD_TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 pad_o,
    output logic                 pad_t,
    output logic                 busy
);

    localparam int               CNT_MAX    = (DATA_BITS > GUARD_BITS) ? DATA_BITS : GUARD_BITS;
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);
    localparam state_t           FIRST_ST   = (GUARD_BITS > 0) ? LEAD : START;
    localparam state_t           END_ST     = (GUARD_BITS > 0) ? TAIL : IDLE;
`ifdef BIDIR_PAD_TX_PARITY_EN
    localparam state_t           AFTER_DATA = PARITY;
`else
    localparam state_t           AFTER_DATA = STOP;
`endif

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_pad_o;
    logic                 r_pad_t;
    logic                 r_tx_ready;
    logic                 r_busy;

    state_t               w_next_state;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_pad_o_nxt;
    logic                 w_xfer;
    logic                 w_tc;
    logic                 w_pre_tc;
    logic                 w_restart;

    assign w_xfer    = tx_valid & r_tx_ready;
    assign w_restart = (w_next_state != r_state);

    bit_period_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_restart(w_restart),
        .o_tc     (w_tc),
        .o_pre_tc (w_pre_tc)
    );

`ifdef BIDIR_PAD_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_parity <= (^tx_data) ^ PARITY_ODD;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_shift_nxt  = tx_data;
                    w_cnt_nxt    = '0;
                    w_next_state = FIRST_ST;
                end
            end
            LEAD, TAIL: begin
                if (w_tc) begin
                    if (r_cnt == GUARD_LAST) begin
                        w_cnt_nxt    = '0;
                        w_next_state = (r_state == LEAD) ? START : IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            START: begin
                if (w_tc) begin
                    w_cnt_nxt    = '0;
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_cnt == DATA_LAST) begin
                        w_cnt_nxt    = '0;
                        w_next_state = AFTER_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef BIDIR_PAD_TX_PARITY_EN
            PARITY: begin
                if (w_tc) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tc) begin
                    w_cnt_nxt = '0;
                    // back-to-back: a frame accepted here skips tail and lead entirely
                    if (w_xfer) begin
                        w_shift_nxt  = tx_data;
                        w_next_state = START;
                    end else begin
                        w_next_state = END_ST;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_pad_o_nxt = LINE_IDLE;
        case (w_next_state)
            START:   w_pad_o_nxt = ~LINE_IDLE;
            DATA:    w_pad_o_nxt = w_shift_nxt[0];
`ifdef BIDIR_PAD_TX_PARITY_EN
            PARITY:  w_pad_o_nxt = r_parity;
`endif
            default: w_pad_o_nxt = LINE_IDLE;
        endcase
    end

    // outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_pad_o    <= LINE_IDLE;
            r_pad_t    <= PAD_HIZ;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pad_o    <= w_pad_o_nxt;
            r_pad_t    <= (w_next_state == IDLE) ? PAD_HIZ : PAD_DRIVE;
            r_tx_ready <= (w_next_state == IDLE) || ((r_state == STOP) && w_pre_tc);
            r_busy     <= (w_next_state != IDLE);
        end
    end

    assign pad_o    = r_pad_o;
    assign pad_t    = r_pad_t;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bidir_pad_tx.sv
// Scoreboard bench for bidir_pad_tx: three parameterisations, per-cycle expected pad waveforms.
module tb_bidir_pad_tx;

    localparam int CPB0 = 4, GB0 = 1, DB0 = 8;
    localparam int CPB1 = 2, GB1 = 0, DB1 = 8;
    localparam int CPB2 = 3, GB2 = 2, DB2 = 5;
`ifdef BIDIR_PAD_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic pad_t;
        logic pad_o;
        logic busy;
        logic ready;
    } obs_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [2:0] tx_valid = '0;
    logic [7:0] tx_data0 = '0;
    logic [7:0] tx_data1 = '0;
    logic [4:0] tx_data2 = '0;
    logic [2:0] tx_ready;
    logic [2:0] pad_o;
    logic [2:0] pad_t;
    logic [2:0] busy;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bidir_pad_tx #(.CLKS_PER_BIT(CPB0), .GUARD_BITS(GB0), .DATA_BITS(DB0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .pad_o(pad_o[0]), .pad_t(pad_t[0]), .busy(busy[0]));

    bidir_pad_tx #(.CLKS_PER_BIT(CPB1), .GUARD_BITS(GB1), .DATA_BITS(DB1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .pad_o(pad_o[1]), .pad_t(pad_t[1]), .busy(busy[1]));

    bidir_pad_tx #(
        .CLKS_PER_BIT(CPB2), .GUARD_BITS(GB2), .DATA_BITS(DB2)
`ifdef BIDIR_PAD_TX_PARITY_EN
        , .PARITY_ODD(1'b1)
`endif
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .pad_o(pad_o[2]), .pad_t(pad_t[2]), .busy(busy[2]));

    function automatic obs_t mk(input logic t, input logic o, input logic b, input logic r);
        obs_t v;
        v.pad_t = t;
        v.pad_o = o;
        v.busy  = b;
        v.ready = r;
        return v;
    endfunction

    function automatic obs_t sample(input int sel);
        return mk(pad_t[sel], pad_o[sel], busy[sel], tx_ready[sel]);
    endfunction

    task automatic set_data(input int sel, input logic [7:0] d);
        case (sel)
            0:       tx_data0 = d;
            1:       tx_data1 = d;
            default: tx_data2 = d[4:0];
        endcase
    endtask

    // Expected per-cycle waveform of one frame, starting the cycle after acceptance.
    task automatic push_frame(input int cpb, input int gb, input int db, input int odd,
                              input logic [7:0] d, input bit lead, input bit tail);
        logic par;
        if (lead) repeat (gb * cpb) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
        repeat (cpb) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        for (int b = 0; b < db; b++)
            repeat (cpb) exp_q.push_back(mk(1'b0, d[b], 1'b1, 1'b0));
        if (PB != 0) begin
            par = (odd != 0);
            for (int b = 0; b < db; b++) par = par ^ d[b];
            repeat (cpb) exp_q.push_back(mk(1'b0, par, 1'b1, 1'b0));
        end
        for (int c = 0; c < cpb; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, c == cpb - 1));
        if (tail) repeat (gb * cpb) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept(input int sel, input logic [7:0] d, input string tag, output bit ok);
        set_data(sel, d);
        tx_valid[sel] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready[sel] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            tx_valid[sel] = 1'b0;
            $display("FAIL %s accept: tx_ready=%b, required 1 within 200 cycles", tag, tx_ready[sel]);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic check_q(input int sel, input string tag, output int drv);
        obs_t e, o;
        int cyc;
        drv = 0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            o = sample(sel);
            if (o.pad_t === 1'b0) drv++;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: t/o/busy/ready got %b required %b", tag, cyc, o, e);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (sample(s) !== mk(1'b1, 1'b1, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL reset_values dut%0d: got %b required 1100", s, sample(s));
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (tx_ready[s] !== 1'b0) begin
                n_err++;
                $display("FAIL ready_first_cycle dut%0d: got %b required 0", s, tx_ready[s]);
            end
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (sample(s) !== mk(1'b1, 1'b1, 1'b0, 1'b1)) begin
                n_err++;
                $display("FAIL ready_after_release dut%0d: got %b required 1101", s, sample(s));
            end
        end
    endtask

    // Single frame; tx_data changes after acceptance and tx_valid pulses while busy.
    task automatic test_single_frame();
        bit ok;
        int drv;
        @(negedge clk);
        accept(0, 8'hA5, "single", ok);
        if (ok) begin
            push_frame(CPB0, GB0, DB0, 0, 8'hA5, 1'b1, 1'b1);
            push_idle(4);
            fork
                check_q(0, "single", drv);
                begin
                    @(negedge clk);
                    tx_valid[0] = 1'b0;
                    tx_data0    = 8'h3C;
                    repeat (10) @(negedge clk);
                    tx_data0    = 8'hFF;
                    tx_valid[0] = 1'b1;
                    @(negedge clk);
                    tx_valid[0] = 1'b0;
                end
            join
            n_vec++;
            if (drv !== (2 * GB0 + 2 + DB0 + PB) * CPB0) begin
                n_err++;
                $display("FAIL single_drive_len: got %0d required %0d", drv, (2 * GB0 + 2 + DB0 + PB) * CPB0);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int drv;
        @(negedge clk);
        accept(0, 8'h00, "b2b", ok);
        if (ok) begin
            push_frame(CPB0, GB0, DB0, 0, 8'h00, 1'b1, 1'b0);
            push_frame(CPB0, GB0, DB0, 0, 8'hFF, 1'b0, 1'b1);
            push_idle(4);
            fork
                check_q(0, "b2b", drv);
                begin
                    @(negedge clk);
                    tx_data0 = 8'hFF;
                    for (int i = 0; i < 200; i++) begin
                        if (tx_ready[0] === 1'b1) break;
                        @(negedge clk);
                    end
                    @(negedge clk);
                    tx_valid[0] = 1'b0;
                end
            join
            // lead + two frames + tail, nothing between the frames
            n_vec++;
            if (drv !== (2 * GB0 + 2 * (2 + DB0 + PB)) * CPB0) begin
                n_err++;
                $display("FAIL b2b_drive_len: got %0d required %0d", drv, (2 * GB0 + 2 * (2 + DB0 + PB)) * CPB0);
            end
        end
    endtask

    task automatic test_no_guard();
        bit ok;
        int drv;
        @(negedge clk);
        accept(1, 8'h01, "no_guard", ok);
        if (ok) begin
            push_frame(CPB1, GB1, DB1, 0, 8'h01, 1'b0, 1'b0);
            push_idle(3);
            fork
                check_q(1, "no_guard", drv);
                begin
                    @(negedge clk);
                    tx_valid[1] = 1'b0;
                end
            join
            n_vec++;
            if (drv !== (2 + DB1 + PB) * CPB1) begin
                n_err++;
                $display("FAIL no_guard_drive_len: got %0d required %0d", drv, (2 + DB1 + PB) * CPB1);
            end
        end
    endtask

    task automatic test_frame(input int sel, input logic [7:0] d, input string tag);
        bit ok;
        int drv;
        @(negedge clk);
        accept(sel, d, tag, ok);
        if (ok) begin
            case (sel)
                0:       push_frame(CPB0, GB0, DB0, 0, d, 1'b1, 1'b1);
                1:       push_frame(CPB1, GB1, DB1, 0, d, 1'b0, 1'b0);
                default: push_frame(CPB2, GB2, DB2, 1, d, 1'b1, 1'b1);
            endcase
            push_idle(3);
            fork
                check_q(sel, tag, drv);
                begin
                    @(negedge clk);
                    tx_valid[sel] = 1'b0;
                    set_data(sel, ~d);
                end
            join
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        @(negedge clk);
        accept(0, 8'hA5, "mid_reset", ok);
        if (ok) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
            repeat (21) @(negedge clk);
            n_vec++;
            if ({pad_t[0], pad_o[0]} !== 2'b00) begin
                n_err++;
                $display("FAIL mid_reset_pre: t/o got %b%b required 00", pad_t[0], pad_o[0]);
            end
            #2 rst_n = 1'b0;
            #1;
            n_vec++;
            if (sample(0) !== mk(1'b1, 1'b1, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL mid_reset_async: got %b required 1100", sample(0));
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            n_vec++;
            if (sample(0) !== mk(1'b1, 1'b1, 1'b0, 1'b1)) begin
                n_err++;
                $display("FAIL mid_reset_idle: got %b required 1101", sample(0));
            end
            test_frame(0, 8'hC3, "after_reset");
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_no_guard();
        test_frame(0, 8'h07, "data_07");
        test_frame(2, 8'h07, "short_frame");
        test_frame(1, 8'h96, "no_guard_96");
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
